// File: rtl/multi_ctrl_if.sv
// Instruction-field and control-strobe bundle between the datapath (master)
// and the multi-cycle controller (slave).
interface multi_ctrl_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic       no_write;
  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state;

  modport master (
    output op, funct, rd,
    input  pcs, reg_w, mem_w, flag_w, no_write, ir_write, next_pc, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src, state
  );

  modport slave (
    input  op, funct, rd,
    output pcs, reg_w, mem_w, flag_w, no_write, ir_write, next_pc, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src, state
  );
endinterface

// File: rtl/multi_ctrl.sv
// Moore multi-cycle controller for a small ARM-like datapath.
// Optional feature: define NO_WRITE_EN to suppress register writeback for CMP.
module multi_ctrl (
  input  logic         clk,
  input  logic         reset,
  multi_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_q;
  state_t     state_d;
  state_t     state_eff;
  logic [3:0] cmd;
  logic       cmp_nw;

  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic       no_write;
  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_control;

  function automatic logic [1:0] alu_dec(input logic [3:0] c);
    case (c)
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: alu_dec = 2'b01;
      default: alu_dec = 2'b00;
    endcase
  endfunction

  // CV flags only make sense for the arithmetic commands
  function automatic logic [1:0] flag_dec(input logic [3:0] c, input logic s);
    logic arith;
    arith    = (c == 4'b0100) || (c == 4'b0010) || (c == 4'b1010);
    flag_dec = {s, s & arith};
  endfunction

  assign cmd = bus.funct[4:1];

`ifdef NO_WRITE_EN
  assign cmp_nw = (bus.op == 2'b00) && (cmd == 4'b1010);
`else
  assign cmp_nw = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          2'b00:   state_d = bus.funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = bus.funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Reset makes the outputs look like FETCH with every strobe held low
  assign state_eff = reset ? FETCH : state_q;

  always_comb begin
    pcs         = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    ir_write    = 1'b0;
    next_pc     = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (state_eff)
      FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR:   alu_src_b = 2'b01;
      MEMREAD:  adr_src   = 1'b1;
      MEMWB: begin
        reg_w      = 1'b1;
        result_src = 2'b01;
        pcs        = (bus.rd == 4'hF);
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        alu_src_b   = (state_eff == EXECUTEI) ? 2'b01 : 2'b00;
        alu_control = alu_dec(cmd);
        flag_w      = flag_dec(cmd, bus.funct[0]);
        no_write    = cmp_nw;
      end
      ALUWB: begin
        reg_w    = ~cmp_nw;
        no_write = cmp_nw;
        pcs      = (bus.rd == 4'hF);
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pcs        = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write = 1'b0;
      next_pc  = 1'b0;
    end
  end

  assign bus.pcs         = pcs;
  assign bus.reg_w       = reg_w;
  assign bus.mem_w       = mem_w;
  assign bus.flag_w      = flag_w;
  assign bus.no_write    = no_write;
  assign bus.ir_write    = ir_write;
  assign bus.next_pc     = next_pc;
  assign bus.adr_src     = adr_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.result_src  = result_src;
  assign bus.alu_control = alu_control;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.state       = state_eff;

endmodule

// File: tb/tb_multi_ctrl.sv
// Directed bench for multi_ctrl: per-cycle expected outputs are queued as each
// instruction is issued and compared as the controller walks its states.
module tb_multi_ctrl;
  logic clk;
  logic reset;
  multi_ctrl_if bus();

  multi_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NO_WRITE_EN
  localparam bit NWE = 1'b1;
`else
  localparam bit NWE = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] cur_imm;
  logic [1:0] cur_rsrc;

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic [1:0] imm, input logic [1:0] rsrc);
    bus.op   = op;
    bus.funct = funct;
    bus.rd   = rd;
    cur_imm  = imm;
    cur_rsrc = rsrc;
  endtask

  task automatic exp(input string tag, input logic [3:0] st, input logic pcs, input logic rw,
                     input logic mw, input logic [1:0] fw, input logic nw, input logic irw,
                     input logic npc, input logic adr, input logic [1:0] sa, input logic [1:0] sbv,
                     input logic [1:0] rs, input logic [1:0] alu);
    exp_t e;
    e.tag = tag;
    e.v   = {st, pcs, rw, mw, fw, nw, irw, npc, adr, sa, sbv, rs, alu, cur_imm, cur_rsrc};
    sb.push_back(e);
  endtask

  task automatic ef(input string tag);
    exp(tag, 4'd0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic ed(input string tag);
    exp(tag, 4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic er(input string tag);
    exp(tag, 4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic chk();
    exp_t        e;
    logic [24:0] obs;
    #1;
    obs = {bus.state, bus.pcs, bus.reg_w, bus.mem_w, bus.flag_w, bus.no_write, bus.ir_write,
           bus.next_pc, bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src,
           bus.alu_control, bus.imm_src, bus.reg_src};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    chk();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  initial begin
    reset = 1'b1;
    set_instr(2'b00, 6'b000000, 4'h0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    er("rst_0"); er("rst_1");
    drain();
    reset = 1'b0;

    // LDR r3
    set_instr(2'b01, 6'b011001, 4'h3, 2'b01, 2'b10);
    ef("ldr_fetch"); ed("ldr_decode");
    exp("ldr_memadr", 4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    exp("ldr_memread", 4'd3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    exp("ldr_memwb", 4'd4, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    drain();

    // STR
    set_instr(2'b01, 6'b011000, 4'h3, 2'b01, 2'b10);
    ef("str_fetch"); ed("str_decode");
    exp("str_memadr", 4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    exp("str_memwrite", 4'd5, 0, 0, 1, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // ADDS immediate to PC
    set_instr(2'b00, 6'b101001, 4'hF, 2'b00, 2'b00);
    ef("adds_fetch"); ed("adds_decode");
    exp("adds_execi", 4'd7, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    exp("adds_aluwb", 4'd8, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // CMP register
    set_instr(2'b00, 6'b010101, 4'h2, 2'b00, 2'b00);
    ef("cmp_fetch"); ed("cmp_decode");
    exp("cmp_execr", 4'd6, 0, 0, 0, 2'b11, NWE, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01);
    exp("cmp_aluwb", 4'd8, 0, ~NWE, 0, 2'b00, NWE, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // ORRS register: NZ only
    set_instr(2'b00, 6'b011001, 4'h1, 2'b00, 2'b00);
    ef("orrs_fetch"); ed("orrs_decode");
    exp("orrs_execr", 4'd6, 0, 0, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11);
    exp("orrs_aluwb", 4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // SUBS register
    set_instr(2'b00, 6'b000101, 4'h0, 2'b00, 2'b00);
    ef("subs_fetch"); ed("subs_decode");
    exp("subs_execr", 4'd6, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01);
    exp("subs_aluwb", 4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // AND register, no S
    set_instr(2'b00, 6'b000000, 4'h4, 2'b00, 2'b00);
    ef("and_fetch"); ed("and_decode");
    exp("and_execr", 4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10);
    exp("and_aluwb", 4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // Unlisted cmd falls back to ADD
    set_instr(2'b00, 6'b100010, 4'h5, 2'b00, 2'b00);
    ef("unk_fetch"); ed("unk_decode");
    exp("unk_execi", 4'd7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    exp("unk_aluwb", 4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();

    // B
    set_instr(2'b10, 6'b000000, 4'h0, 2'b10, 2'b01);
    ef("b_fetch"); ed("b_decode");
    exp("b_branch", 4'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00);
    drain();

    // Undefined op
    set_instr(2'b11, 6'b111111, 4'hF, 2'b11, 2'b00);
    ef("undef_fetch"); ed("undef_decode");
    drain();

    // LDR into PC
    set_instr(2'b01, 6'b011001, 4'hF, 2'b01, 2'b10);
    ef("ldrpc_fetch"); ed("ldrpc_decode");
    exp("ldrpc_memadr", 4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    exp("ldrpc_memread", 4'd3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    exp("ldrpc_memwb", 4'd4, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    drain();

    // Reset held two cycles while in MEMREAD
    set_instr(2'b01, 6'b011001, 4'h3, 2'b01, 2'b10);
    ef("mr_fetch"); ed("mr_decode");
    exp("mr_memadr", 4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    drain();
    exp("mr_memread", 4'd3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    chk();
    reset = 1'b1;
    er("mr_rst_0"); er("mr_rst_1");
    drain();
    reset = 1'b0;
    set_instr(2'b11, 6'b000000, 4'h0, 2'b11, 2'b00);
    ef("post_rst_fetch"); ed("post_rst_decode");
    drain();
    ef("end_fetch");
    chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
